// File: rtl/cla_sub_pipe.sv
// Pipelined subtractor: a + ~b + 1 resolved one 4-bit carry-lookahead slice per rank,
// with a valid/ready handshake and a global stall that freezes every rank together.
module cla_sub_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_overflow
);

  localparam int STAGES = WIDTH / 4;

  logic             w_stall;
  logic             r_v0;
  logic [WIDTH-1:0] r_a0;
  logic [WIDTH-1:0] r_bn0;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  assign w_stall  = out_valid & ~out_ready;
  assign in_ready = ~w_stall;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_v0 <= 1'b0;
    end else if (!w_stall) begin
      r_v0 <= in_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (!w_stall) begin
      r_a0  <= in_a;
      r_bn0 <= ~in_b;
    end
  end

  // Rank k keeps only operand bits still needed: the unresolved slices, or just the
  // MSBs at the final rank where they feed the overflow flag.
  for (genvar k = 1; k <= STAGES; k++) begin : g_rank
    localparam int LB = (k < STAGES) ? 4 * k : WIDTH - 1;
    localparam int PL = 4 * (k - 1);

    logic               r_v;
    logic               r_c;
    logic [4*k-1:0]     r_d;
    logic [WIDTH-1:LB]  r_a;
    logic [WIDTH-1:LB]  r_bn;
    logic [WIDTH-1:PL]  w_pa;
    logic [WIDTH-1:PL]  w_pbn;
    logic               w_pv;
    logic               w_ci;
    logic [4:0]         w_s;
    logic [4*k-1:0]     w_dn;

    if (k == 1) begin : g_first
      assign w_pa  = r_a0;
      assign w_pbn = r_bn0;
      assign w_pv  = r_v0;
      assign w_ci  = 1'b1;
      assign w_dn  = w_s[3:0];
    end else begin : g_next
      assign w_pa  = g_rank[k-1].r_a;
      assign w_pbn = g_rank[k-1].r_bn;
      assign w_pv  = g_rank[k-1].r_v;
      assign w_ci  = g_rank[k-1].r_c;
      assign w_dn  = {w_s[3:0], g_rank[k-1].r_d};
    end

    assign w_s = cla4(w_pa[PL+3:PL], w_pbn[PL+3:PL], w_ci);

    always_ff @(posedge clock) begin
      if (!reset) begin
        r_v <= 1'b0;
      end else if (!w_stall) begin
        r_v <= w_pv;
      end
    end

    always_ff @(posedge clock) begin
      if (!w_stall) begin
        r_a  <= w_pa[WIDTH-1:LB];
        r_bn <= w_pbn[WIDTH-1:LB];
        r_c  <= w_s[4];
        r_d  <= w_dn;
      end
    end
  end

  logic             w_a_msb;
  logic             w_b_msb;
  logic [WIDTH-1:0] w_diff;

  assign w_a_msb = g_rank[STAGES].r_a[WIDTH-1];
  assign w_b_msb = ~g_rank[STAGES].r_bn[WIDTH-1];
  assign w_diff  = g_rank[STAGES].r_d;

  // Result outputs are forced to zero whenever the final rank holds a bubble.
  assign out_valid    = g_rank[STAGES].r_v;
  assign out_diff     = out_valid ? w_diff : '0;
  assign out_borrow   = out_valid & ~g_rank[STAGES].r_c;
  assign out_overflow = out_valid & (w_a_msb ^ w_b_msb) & (w_diff[WIDTH-1] ^ w_a_msb);

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed bench for cla_sub_pipe (WIDTH=16): reset, latency, flags, streaming,
// backpressure and mid-flight reset, with hand-computed expected results.
module tb_cla_sub_pipe;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_overflow;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] va [8];
  logic [W-1:0] vb [8];
  logic [W-1:0] vd [8];
  logic         vbo[8];
  logic         vov[8];

  always #5 clock = ~clock;

  cla_sub_pipe #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_diff    (out_diff),
    .out_borrow  (out_borrow),
    .out_overflow(out_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] d, input logic bo, input logic ov);
    int lat;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (!out_valid && lat < 10);
    chk({tag, "_latency"}, lat, 4);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_diff"}, out_diff, d);
    chk({tag, "_borrow"}, out_borrow, bo);
    chk({tag, "_overflow"}, out_overflow, ov);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int ii;
    int ri;

    va  = '{16'h0005, 16'h0003, 16'h7FFF, 16'hFFFF, 16'h00F0, 16'hABCD, 16'h0F0F, 16'h8000};
    vb  = '{16'h0003, 16'h0005, 16'hFFFF, 16'hFFFF, 16'h000F, 16'h1234, 16'h00F1, 16'h7FFF};
    vd  = '{16'h0002, 16'hFFFE, 16'h8000, 16'h0000, 16'h00E1, 16'h9999, 16'h0E1E, 16'h0001};
    vbo = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vov = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // reset held two edges with in_valid asserted
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_a      = 16'h1111;
    in_b      = 16'h0001;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_diff", out_diff, 0);
    chk("rst_borrow", out_borrow, 0);
    chk("rst_overflow", out_overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    reset    = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_quiet", out_valid, 0);
    end

    run_one("single", 16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0);
    run_one("under",  16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0);
    run_one("ovf",    16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
    run_one("xslice", 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0);
    run_one("equal",  16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b0);
    run_one("max_b",  16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0);

    // back-to-back: results on consecutive cycles starting four edges after first accept
    for (int c = 0; c < 13; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        in_a     = va[c];
        in_b     = vb[c];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (c >= 4 && c < 12) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_diff", out_diff, vd[c-4]);
        chk("b2b_borrow", out_borrow, vbo[c-4]);
        chk("b2b_overflow", out_overflow, vov[c-4]);
      end else begin
        chk("b2b_idle", out_valid, 0);
      end
    end

    // backpressure: full pipeline, out_ready low for three cycles
    ii = 0;
    ri = 0;
    for (int c = 0; c < 30 && ri < 8; c++) begin
      out_ready = !(c >= 5 && c < 8);
      if (ii < 8) begin
        in_valid = 1'b1;
        in_a     = va[ii];
        in_b     = vb[ii];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 5 && c < 8) begin
        chk("bp_stall_in_ready", in_ready, 0);
        chk("bp_stall_valid", out_valid, 1);
      end
      if (c == 8) chk("bp_release_in_ready", in_ready, 1);
      if (out_valid) begin
        if (ri < 8) begin
          chk("bp_diff", out_diff, vd[ri]);
          chk("bp_borrow", out_borrow, vbo[ri]);
          chk("bp_overflow", out_overflow, vov[ri]);
          if (out_ready) ri++;
        end else begin
          chk("bp_extra_result", out_valid, 0);
        end
      end
      if (in_valid && in_ready) ii++;
      step();
    end
    chk("bp_delivered", ri, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_drained", out_valid, 0);
    end

    // mid-flight reset with three operations in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1;
      in_a     = va[c];
      in_b     = vb[c];
      step();
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mid_rst_quiet", out_valid, 0);
    end
    run_one("post_rst", 16'h0F0F, 16'h00F1, 16'h0E1E, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_sub_pipe.md
# cla_sub_pipe

Pipelined WIDTH-bit subtractor computing in_a − in_b with borrow and signed-overflow flags. It is built from 4-bit carry-lookahead slices, with one slice resolved per pipeline rank. It is the subtract-side counterpart to the fast CLA adders and sits on the same operand path. Unlike the adders, it carries a valid/ready handshake on both ends so it can be back-pressured by downstream consumers.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4.
- STAGES, WIDTH/4, number of slice ranks. This is derived and must not be overridden.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising clock edge.
- in_valid  input  1  operand pair present on in_a/in_b.
- in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
- in_a  input  WIDTH  minuend.
- in_b  input  WIDTH  subtrahend.
- out_valid  output  1  result present on out_* outputs.
- out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready at a rising edge.
- out_diff  output  WIDTH  (in_a − in_b) mod 2^WIDTH.
- out_borrow  output  1  1 when in_a < in_b, treating operands as unsigned.
- out_overflow  output  1  1 when the signed two's-complement result does not fit in WIDTH bits.

## Operation
- The difference is computed as in_a + ~in_b + 1. The carry-in to slice 0 is 1.
- Rank 0 captures in_a, ~in_b and a valid bit on each accepting edge.
- Rank k (1..STAGES) computes 4-bit slice k−1 using a CLA on the operand bits carried forward from rank k−1. Its carry-in is rank k−1's carry-out.
- Rank k registers:
  - the resolved slices 0..k−1;
  - the unresolved operand bits;
  - the carry;
  - a valid bit.
- The final rank drives the outputs directly:
  - out_diff is the registered resolved slices.
  - out_borrow = ~carry-out of slice STAGES−1.
  - out_overflow = (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]). The operand MSBs are carried to the final rank for this.
- Stall: stall = out_valid && !out_ready.
  - When stall = 1, every rank holds its contents, including valid bits and data.
  - When stall = 0, every rank advances by one.
- in_ready = !stall. It is combinational from out_valid and out_ready.
- Bubbles (invalid ranks) advance like data. The pipeline does not compress them.
- Data in an invalid rank is don't-care internally, but out_diff, out_borrow and out_overflow must read 0 while out_valid = 0.
- Results emerge strictly in acceptance order, with no loss or duplication.

## Timing
- Reset (reset = 0 at a rising edge):
  - all valid bits clear;
  - out_valid = 0, out_diff = 0, out_borrow = 0, out_overflow = 0;
  - in_ready = 1 from the first edge after reset is applied;
  - in_valid is ignored while reset = 0.
- Reset mid-operation: all in-flight operations are discarded at that edge. No stale result appears after reset is released.
- Latency: an operand accepted at edge T produces out_valid = 1 after edge T+STAGES, provided no stall occurs in between. For WIDTH = 16 that is 4 edges.
  - Each stall cycle adds exactly one cycle.
- Throughput: one operation per cycle while out_ready = 1.
- Output stability: out_diff, out_borrow and out_overflow hold stable from out_valid rising until the transfer edge.
- Simultaneous events:
  - An output transfer and an input accept on the same edge are both legal; the pipeline shifts.
  - If stall = 1 and out_ready rises, the stall is released combinationally. in_ready rises in the same cycle.
- Boundary values:
  - a = b gives diff 0, borrow 0.
  - a = 0, b = 2^WIDTH−1 gives diff 1, borrow 1.
  - The carry must ripple correctly across every slice boundary.

## Test plan
- **Reset:** hold reset = 0 for 2 edges with in_valid = 1 → out_valid = 0, outputs all 0, in_ready = 1; no result emerges afterward.
- **Single operation:** with out_ready = 1, accept 0x1234 − 0x0234 at edge T → at T+4: out_valid = 1, out_diff = 0x1000, borrow = 0, overflow = 0.
- **Borrow and overflow:**
  - 0x0000 − 0x0001 → 0xFFFF, borrow = 1, overflow = 0.
  - 0x8000 − 0x0001 → 0x7FFF, borrow = 0, overflow = 1.
  - 0x1000 − 0x0001 → 0x0FFF (cross-slice borrow).
- **Back-to-back:** issue 8 consecutive random pairs with out_ready = 1 → 8 consecutive out_valid cycles starting at T+4, in order, each matching the reference model.
- **Backpressure:** with the pipeline full, drop out_ready for 3 cycles → in_ready = 0 for those 3 cycles, out_diff held constant; after release, all results delivered in order with none lost or duplicated.
- **Mid-flight reset:** with 3 operations in flight, pulse reset = 0 for 1 edge → out_valid = 0 thereafter until new operands are accepted; the first post-reset result appears exactly 4 edges after its acceptance.
